// File: rtl/mixed_range_ser_tx.sv
// Framed serial transmitter for one descending [HI:LO] bus and one ascending [LO:HI] bus.
// Define MIXED_RANGE_SER_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module mixed_range_ser_tx #(
  parameter int HI         = 2,
  parameter int LO         = -2,
  parameter int BIT_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [HI:LO] i0,
  input  logic [LO:HI] i1,
  output logic         sdo,
  output logic         busy,
  output logic         frame_done
);

  localparam int W  = HI - LO + 1;
  localparam int NB = 2 * W;
  localparam int BW = $clog2(NB + 3);
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

`ifdef MIXED_RANGE_SER_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state, state_nx;
  logic [CW-1:0]   cyc, cyc_nx;
  logic [BW-1:0]   bit_cnt, bit_nx;
  logic [NB-1:0]   shreg, shreg_nx;
  logic            sdo_nx, busy_nx, done_nx, ready_nx;
  logic            last_cyc;
  logic            transfer;
`ifdef MIXED_RANGE_SER_TX_PARITY_EN
  logic            par, par_nx;
`endif

  assign last_cyc = (cyc == CW'(BIT_CYCLES - 1));
  assign transfer = in_valid & in_ready;

  // {i0, i1} puts i0[HI] at the MSB and i1[LO] right after i0[LO], so shifting
  // out MSB-first sends both buses in declaration left-to-right order.
  always_comb begin
    state_nx = state;
    cyc_nx   = cyc;
    bit_nx   = bit_cnt;
    shreg_nx = shreg;
    sdo_nx   = sdo;
    busy_nx  = busy;
    done_nx  = 1'b0;
    ready_nx = 1'b0;
`ifdef MIXED_RANGE_SER_TX_PARITY_EN
    par_nx   = par;
`endif
    case (state)
      IDLE: begin
        ready_nx = 1'b1;
        sdo_nx   = 1'b1;
        busy_nx  = 1'b0;
        if (transfer) begin
          state_nx = START;
          cyc_nx   = '0;
          bit_nx   = '0;
          shreg_nx = {i0, i1};
`ifdef MIXED_RANGE_SER_TX_PARITY_EN
          par_nx   = ^{i0, i1};
`endif
          sdo_nx   = 1'b0;
          busy_nx  = 1'b1;
          ready_nx = 1'b0;
        end
      end
      START: begin
        if (last_cyc) begin
          state_nx = DATA;
          cyc_nx   = '0;
          sdo_nx   = shreg[NB-1];
          shreg_nx = shreg << 1;
          bit_nx   = bit_cnt + BW'(1);
        end else begin
          cyc_nx = cyc + CW'(1);
        end
      end
      DATA: begin
        if (last_cyc) begin
          cyc_nx = '0;
          if (bit_cnt == BW'(NB)) begin
            bit_nx = bit_cnt + BW'(1);
`ifdef MIXED_RANGE_SER_TX_PARITY_EN
            state_nx = PARITY;
            sdo_nx   = par;
`else
            state_nx = STOP;
            sdo_nx   = 1'b1;
            done_nx  = (BIT_CYCLES == 1);
`endif
          end else begin
            sdo_nx   = shreg[NB-1];
            shreg_nx = shreg << 1;
            bit_nx   = bit_cnt + BW'(1);
          end
        end else begin
          cyc_nx = cyc + CW'(1);
        end
      end
`ifdef MIXED_RANGE_SER_TX_PARITY_EN
      PARITY: begin
        if (last_cyc) begin
          state_nx = STOP;
          cyc_nx   = '0;
          bit_nx   = bit_cnt + BW'(1);
          sdo_nx   = 1'b1;
          done_nx  = (BIT_CYCLES == 1);
        end else begin
          cyc_nx = cyc + CW'(1);
        end
      end
`endif
      STOP: begin
        if (last_cyc) begin
          state_nx = IDLE;
          cyc_nx   = '0;
          bit_nx   = '0;
          sdo_nx   = 1'b1;
          busy_nx  = 1'b0;
          ready_nx = 1'b1;
        end else begin
          cyc_nx  = cyc + CW'(1);
          done_nx = (int'(cyc) + 2 == BIT_CYCLES);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // All outputs are flops so sdo never glitches; reset drives the line idle at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cyc        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      sdo        <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      in_ready   <= 1'b0;
`ifdef MIXED_RANGE_SER_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      cyc        <= cyc_nx;
      bit_cnt    <= bit_nx;
      shreg      <= shreg_nx;
      sdo        <= sdo_nx;
      busy       <= busy_nx;
      frame_done <= done_nx;
      in_ready   <= ready_nx;
`ifdef MIXED_RANGE_SER_TX_PARITY_EN
      par        <= par_nx;
`endif
    end
  end

endmodule

// File: tb/tb_mixed_range_ser_tx.sv
// Self-checking bench for mixed_range_ser_tx: queue-based frame model on the default
// instance, plus literal frame checks on BIT_CYCLES=3 and HI=0/LO=-3 instances.
module tb_mixed_range_ser_tx;

  localparam int HI = 2;
  localparam int LO = -2;
  localparam int W  = HI - LO + 1;
`ifdef MIXED_RANGE_SER_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = 2 * W + 2 + PAR;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         valid_a = 1'b0;
  logic [HI:LO] i0_a    = '0;
  logic [LO:HI] i1_a    = '0;
  logic         ready_a, sdo_a, busy_a, done_a;

  logic         valid_b = 1'b0;
  logic [2:-2]  i0_b    = '0;
  logic [-2:2]  i1_b    = '0;
  logic         ready_b, sdo_b, busy_b, done_b;

  logic         valid_c = 1'b0;
  logic [0:-3]  i0_c    = '0;
  logic [-3:0]  i1_c    = '0;
  logic         ready_c, sdo_c, busy_c, done_c;

  mixed_range_ser_tx u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(valid_a), .in_ready(ready_a),
    .i0(i0_a), .i1(i1_a), .sdo(sdo_a), .busy(busy_a), .frame_done(done_a)
  );

  mixed_range_ser_tx #(.HI(2), .LO(-2), .BIT_CYCLES(3)) u_slow (
    .clk(clk), .rst_n(rst_n), .in_valid(valid_b), .in_ready(ready_b),
    .i0(i0_b), .i1(i1_b), .sdo(sdo_b), .busy(busy_b), .frame_done(done_b)
  );

  mixed_range_ser_tx #(.HI(0), .LO(-3), .BIT_CYCLES(1)) u_neg (
    .clk(clk), .rst_n(rst_n), .in_valid(valid_c), .in_ready(ready_c),
    .i0(i0_c), .i1(i1_c), .sdo(sdo_c), .busy(busy_c), .frame_done(done_c)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_output(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: a queue of per-cycle {sdo, busy, frame_done} expectations built from the frame rules.
  logic [2:0] exp_q[$];
  logic m_sdo = 1'b1, m_busy = 1'b0, m_done = 1'b0, m_ready = 1'b0;

  function automatic void push_frame(input logic [HI:LO] a, input logic [LO:HI] b);
    logic fields[$];
    fields.push_back(1'b0);
    for (int k = HI; k >= LO; k--) fields.push_back(a[k]);
    for (int k = LO; k <= HI; k++) fields.push_back(b[k]);
    if (PAR != 0) fields.push_back((^a) ^ (^b));
    fields.push_back(1'b1);
    for (int f = 0; f < fields.size(); f++)
      exp_q.push_back({fields[f], 1'b1, (f == fields.size() - 1) ? 1'b1 : 1'b0});
  endfunction

  initial begin
    logic go, took;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        {m_sdo, m_busy, m_done} = 3'b100;
        m_ready = 1'b0;
      end else begin
        go   = valid_a && m_ready;
        took = (exp_q.size() != 0);
        if (go) push_frame(i0_a, i1_a);
        if (exp_q.size() != 0) {m_sdo, m_busy, m_done} = exp_q.pop_front();
        else {m_sdo, m_busy, m_done} = 3'b100;
        m_ready = !go && !took;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    check_output("model_sdo", sdo_a, m_sdo);
    check_output("model_busy", busy_a, m_busy);
    check_output("model_frame_done", done_a, m_done);
    check_output("model_in_ready", ready_a, m_ready);
  end

  function automatic logic [3:0] probe(input int which);
    if (which == 1) return {sdo_b, busy_b, done_b, ready_b};
    return {sdo_c, busy_c, done_c, ready_c};
  endfunction

  task automatic set_valid(input int which, input logic v);
    if (which == 1) valid_b = v;
    else valid_c = v;
  endtask

  // Sends one frame on instance 1 or 2 and compares sdo against a literal bit string.
  task automatic apply_stimulus(input int which, input string name,
                                input logic [63:0] exp_bits, input int len);
    logic [3:0] o;
    int n = 0;
    o = probe(which);
    while (!o[0] && n < 50) begin
      @(negedge clk);
      o = probe(which);
      n++;
    end
    check_output({name, "_ready"}, o[0], 1'b1);
    if (!o[0]) return;
    set_valid(which, 1'b1);
    @(posedge clk);
    #2 set_valid(which, 1'b0);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      o = probe(which);
      check_output({name, "_sdo"}, o[3], exp_bits[len-1-k]);
      check_output({name, "_busy"}, o[2], 1'b1);
      check_output({name, "_frame_done"}, o[1], (k == len - 1) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    o = probe(which);
    check_output({name, "_idle_sdo"}, o[3], 1'b1);
    check_output({name, "_idle_busy"}, o[2], 1'b0);
  endtask

  initial begin
    logic [12:0] lit;
    logic [63:0] e;
    logic        fq[$];
    int          n, g, rc;

    $display("[TB] start, parity=%0d frame_len=%0d", PAR, FL);
    #1 rst_n = 1'b0;

    // Reset release with in_valid held high, then the reference frame
    i0_a = 5'h13;
    i1_a = 5'b01011;
    valid_a = 1'b1;
    repeat (3) @(negedge clk);
    check_output("rst_in_ready", ready_a, 1'b0);
    check_output("rst_sdo", sdo_a, 1'b1);
    check_output("rst_busy", busy_a, 1'b0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_output("rel_in_ready", ready_a, 1'b1);
    check_output("rel_busy", busy_a, 1'b0);
    if (PAR != 0) lit = 13'b0_10011_01011_0_1;
    else lit = {1'b0, 12'b0_10011_01011_1};
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      valid_a = 1'b0;
      check_output("lit_sdo", sdo_a, lit[FL-1-k]);
      check_output("lit_frame_done", done_a, (k == FL - 1) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    check_output("lit_idle_sdo", sdo_a, 1'b1);

    // Back-to-back frames with in_valid held: exactly one idle cycle between them
    valid_a = 1'b1;
    n = 0;
    while (!busy_a && n < 40) begin
      @(negedge clk);
      i0_a = 5'($urandom);
      i1_a = 5'($urandom);
      n++;
    end
    check_output("b2b_first_busy", busy_a, 1'b1);
    n = 0;
    while (busy_a && n < 40) begin
      @(negedge clk);
      i0_a = 5'($urandom);
      i1_a = 5'($urandom);
      n++;
    end
    g = 0;
    rc = 0;
    while (!busy_a && g < 10) begin
      g++;
      if (ready_a) rc++;
      @(negedge clk);
    end
    check_int("b2b_idle_gap", g, 1);
    check_int("b2b_ready_cycles", rc, 1);
    valid_a = 1'b0;
    repeat (FL + 3) @(negedge clk);

    // Randomized traffic, checked cycle by cycle against the model
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      valid_a = ($urandom_range(0, 2) == 0);
      i0_a = 5'($urandom);
      i1_a = 5'($urandom);
    end
    valid_a = 1'b0;
    repeat (FL + 3) @(negedge clk);

    // Reset pulled on the 4th data bit
    n = 0;
    while (!ready_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_output("mid_ready", ready_a, 1'b1);
    i0_a = 5'h1C;
    i1_a = 5'h03;
    valid_a = 1'b1;
    @(posedge clk);
    #2 valid_a = 1'b0;
    repeat (4) @(posedge clk);
    #2 check_output("mid_pre_reset_sdo", sdo_a, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check_output("mid_async_sdo", sdo_a, 1'b1);
    check_output("mid_async_busy", busy_a, 1'b0);
    check_output("mid_async_done", done_a, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    while (!ready_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_output("post_rst_ready", ready_a, 1'b1);
    i0_a = 5'h05;
    i1_a = 5'h1A;
    valid_a = 1'b1;
    @(posedge clk);
    #2 valid_a = 1'b0;
    repeat (FL + 3) @(negedge clk);

    // BIT_CYCLES=3, i0=0, i1=all ones
    i0_b = 5'h00;
    i1_b = 5'h1F;
    fq.push_back(1'b0);
    for (int k = 0; k < 5; k++) fq.push_back(1'b0);
    for (int k = 0; k < 5; k++) fq.push_back(1'b1);
    if (PAR != 0) fq.push_back(1'b1);
    fq.push_back(1'b1);
    e = '0;
    for (int f = 0; f < fq.size(); f++)
      for (int r = 0; r < 3; r++) e = {e[62:0], fq[f]};
    apply_stimulus(1, "slow", e, FL * 3);

    // HI=0, LO=-3 override
    i0_c = 4'hA;
    i1_c = 4'h5;
    if (PAR != 0) e = 64'(11'b0_1010_0101_0_1);
    else e = 64'(10'b0_1010_0101_1);
    apply_stimulus(2, "neg", e, 10 + PAR);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
